ikbd_host_acia: RTL and testbench

//  Host-side MC6850-style ACIA: the other end of the HD63701 SCI serial link (8N1).

---
 rtl/ikbd_host_acia.sv | 349 ++++++++++++++++++++++++++++++++++
 tb/tb_ikbd_host_acia.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ikbd_host_acia.sv
// ikbd_host_acia
// Host-side MC6850-style ACIA. This block is the far end of the HD63701 SCI
// serial link, which always runs 8N1. It turns host data writes into a serial
// stream on TXD, which drives the MCU's SCI receive pin. It also turns the
// MCU's SCI transmit stream (RXD) into a receive data register that the host
// can read.
//
// Ports
//   CLK     system clock; all registers update on the rising edge
//   RST     asynchronous reset, active high
//   CLK_EN  baud tick, one CLK wide; 16 or 64 ticks make one bit
//   CS/STB  an access happens only on a cycle where CS & STB are both high
//   RS      0 = control (write) / status (read); 1 = TDR (write) / RDR (read)
//   RW      1 = write, 0 = read
//   DI      host write data
//   DO      read data, combinational from RS
//   IRQ     interrupt request, active high
//   RXD     serial in from the MCU SCI TX
//   TXD     serial out to the MCU SCI RX
//   RTS_n   request to send, active low
module ikbd_host_acia #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       CLK_EN,
  input  logic       CS,
  input  logic       STB,
  input  logic       RS,
  input  logic       RW,
  input  logic [7:0] DI,
  output logic [7:0] DO,
  output logic       IRQ,
  input  logic       RXD,
  output logic       TXD,
  output logic       RTS_n
);

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_t;

  // Host-visible registers and flags
  logic [7:0] cr_q, cr_d;
  logic       mr_q, mr_d;
  logic [7:0] tdr_q, tdr_d;
  logic [7:0] rdr_q, rdr_d;
  logic       tdre_q, tdre_d;
  logic       rdrf_q, rdrf_d;
  logic       fe_q, fe_d;
  logic       ovrn_q, ovrn_d;

  // Receiver
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic       rx_prev_q, rx_prev_d;
  rx_state_t  rx_state_q, rx_state_d;
  logic [5:0] rx_cnt_q, rx_cnt_d;
  logic [2:0] rx_idx_q, rx_idx_d;
  logic [7:0] rx_shift_q, rx_shift_d;
  logic       rx_len64_q, rx_len64_d;

  // Transmitter
  tx_state_t  tx_state_q, tx_state_d;
  logic [5:0] tx_cnt_q, tx_cnt_d;
  logic [2:0] tx_idx_q, tx_idx_d;
  logic [7:0] tx_shift_q, tx_shift_d;
  logic       tx_len64_q, tx_len64_d;
  logic       txd_q, txd_d;

  // Decoded helpers
  logic       acc, ctrl_wr, data_wr, data_rd;
  logic       brk, len64_now;
  logic       rx_sync;
  logic [5:0] rx_last, rx_half, tx_last;
  logic       tx_load, rx_land;
  logic [7:0] status;

  // The word-select bits CR[4:2] are kept so the register reads back
  // like a real 6850, but the link framing is fixed at 8N1.
  logic       unused_word_select;
  assign unused_word_select = ^cr_q[4:2];

  assign acc     = CS & STB;
  assign ctrl_wr = acc & RW & ~RS;
  assign data_wr = acc & RW & RS;
  assign data_rd = acc & ~RW & RS;

  assign brk       = (cr_q[6:5] == 2'b11);
  assign len64_now = (cr_q[1:0] == 2'b10);
  assign rx_sync   = sync_q[SYNC_STAGES-1];

  // Each FSM latches the bit length at every bit boundary. A divide change
  // written mid-frame is therefore picked up at the next boundary.
  assign rx_last = rx_len64_q ? 6'd63 : 6'd15;
  assign rx_half = rx_len64_q ? 6'd31 : 6'd7;
  assign tx_last = tx_len64_q ? 6'd63 : 6'd15;

  assign IRQ    = (cr_q[7] & (rdrf_q | ovrn_q)) | ((cr_q[6:5] == 2'b01) & tdre_q);
  assign status = {IRQ, 1'b0, ovrn_q, fe_q, 1'b0, 1'b0, tdre_q, rdrf_q};
  assign DO     = RS ? rdr_q : status;
  assign TXD    = txd_q;
  assign RTS_n  = (cr_q[6:5] == 2'b10);

  // Next-state logic. The statement order matters:
  //   1. The TX FSM can set TDRE on a load.
  //   2. A host data write on the same cycle still leaves TDRE clear, so the
  //      newly written byte stays pending.
  //   3. A host data read clears RDRF/OVRN before the RX landing logic runs.
  //      A byte landing on the same cycle as a read is accepted, not overrun.
  //   4. Master reset overrides everything else.
  always_comb begin
    cr_d       = cr_q;
    mr_d       = mr_q;
    tdr_d      = tdr_q;
    rdr_d      = rdr_q;
    tdre_d     = tdre_q;
    rdrf_d     = rdrf_q;
    fe_d       = fe_q;
    ovrn_d     = ovrn_q;
    sync_d     = {sync_q[SYNC_STAGES-2:0], RXD};
    rx_prev_d  = rx_sync;
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_idx_d   = rx_idx_q;
    rx_shift_d = rx_shift_q;
    rx_len64_d = rx_len64_q;
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_idx_d   = tx_idx_q;
    tx_shift_d = tx_shift_q;
    tx_len64_d = tx_len64_q;
    txd_d      = txd_q;
    tx_load    = 1'b0;
    rx_land    = 1'b0;

    // Transmitter
    if (!mr_q) begin
      if (brk) begin
        // Break aborts the frame and holds the line low; TDR is untouched.
        tx_state_d = TX_IDLE;
        tx_cnt_d   = '0;
        tx_idx_d   = '0;
        txd_d      = 1'b0;
      end else begin
        case (tx_state_q)
          TX_IDLE: begin
            txd_d = 1'b1;
            if (CLK_EN && !tdre_q) tx_load = 1'b1;
          end
          default: begin
            if (CLK_EN) begin
              if (tx_cnt_q != tx_last) begin
                tx_cnt_d = tx_cnt_q + 6'd1;
              end else begin
                tx_cnt_d   = '0;
                tx_len64_d = len64_now;
                if (tx_state_q == TX_START) begin
                  txd_d      = tx_shift_q[0];
                  tx_shift_d = {1'b0, tx_shift_q[7:1]};
                  tx_idx_d   = '0;
                  tx_state_d = TX_DATA;
                end else if (tx_state_q == TX_DATA) begin
                  if (tx_idx_q == 3'd7) begin
                    txd_d      = 1'b1;
                    tx_state_d = TX_STOP;
                  end else begin
                    txd_d      = tx_shift_q[0];
                    tx_shift_d = {1'b0, tx_shift_q[7:1]};
                    tx_idx_d   = tx_idx_q + 3'd1;
                  end
                end else begin
                  // End of the stop bit. Chain straight into the next
                  // frame if a byte is waiting, so there is no idle gap.
                  if (!tdre_q) begin
                    tx_load = 1'b1;
                  end else begin
                    tx_state_d = TX_IDLE;
                    txd_d      = 1'b1;
                  end
                end
              end
            end
          end
        endcase
        if (tx_load) begin
          tx_shift_d = tdr_q;
          tdre_d     = 1'b1;
          txd_d      = 1'b0;
          tx_state_d = TX_START;
          tx_cnt_d   = '0;
          tx_idx_d   = '0;
          tx_len64_d = len64_now;
        end
      end
    end

    // Host writes
    if (ctrl_wr) begin
      cr_d = DI;
      mr_d = (DI[1:0] == 2'b11);
    end
    if (data_wr) begin
      tdr_d  = DI;
      tdre_d = 1'b0;
    end

    // Host reads; status reads have no side effects.
    if (data_rd) begin
      rdrf_d = 1'b0;
      ovrn_d = 1'b0;
    end

    // Receiver
    if (!mr_q) begin
      case (rx_state_q)
        RX_IDLE: begin
          if (rx_prev_q && !rx_sync) begin
            rx_state_d = RX_START;
            rx_cnt_d   = '0;
            rx_len64_d = len64_now;
          end
        end
        RX_START: begin
          if (CLK_EN) begin
            if (rx_cnt_q != rx_half) begin
              rx_cnt_d = rx_cnt_q + 6'd1;
            end else begin
              // Mid-start sample. A high level here means the line only
              // glitched, so drop back to idle without touching any flag.
              rx_cnt_d   = '0;
              rx_idx_d   = '0;
              rx_len64_d = len64_now;
              rx_state_d = rx_sync ? RX_IDLE : RX_DATA;
            end
          end
        end
        RX_DATA: begin
          if (CLK_EN) begin
            if (rx_cnt_q != rx_last) begin
              rx_cnt_d = rx_cnt_q + 6'd1;
            end else begin
              rx_cnt_d   = '0;
              rx_len64_d = len64_now;
              rx_shift_d = {rx_sync, rx_shift_q[7:1]};
              if (rx_idx_q == 3'd7) rx_state_d = RX_STOP;
              else rx_idx_d = rx_idx_q + 3'd1;
            end
          end
        end
        default: begin
          if (CLK_EN) begin
            if (rx_cnt_q != rx_last) begin
              rx_cnt_d = rx_cnt_q + 6'd1;
            end else begin
              rx_cnt_d   = '0;
              rx_state_d = RX_IDLE;
              rx_land    = 1'b1;
            end
          end
        end
      endcase
    end

    if (rx_land) begin
      if (rdrf_q && !data_rd) begin
        ovrn_d = 1'b1;
      end else begin
        rdr_d  = rx_shift_q;
        rdrf_d = 1'b1;
        fe_d   = ~rx_sync;
      end
    end

    // Master reset holds both FSMs idle and clears all flags.
    // Leaving master reset marks the transmit register as empty.
    if (mr_d) begin
      tdre_d     = 1'b0;
      rdrf_d     = 1'b0;
      fe_d       = 1'b0;
      ovrn_d     = 1'b0;
      rx_state_d = RX_IDLE;
      rx_cnt_d   = '0;
      tx_state_d = TX_IDLE;
      tx_cnt_d   = '0;
      txd_d      = 1'b1;
    end else if (mr_q) begin
      tdre_d = 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cr_q       <= 8'h03;
      mr_q       <= 1'b1;
      tdr_q      <= '0;
      rdr_q      <= '0;
      tdre_q     <= 1'b0;
      rdrf_q     <= 1'b0;
      fe_q       <= 1'b0;
      ovrn_q     <= 1'b0;
      sync_q     <= '1;
      rx_prev_q  <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_idx_q   <= '0;
      rx_shift_q <= '0;
      rx_len64_q <= 1'b0;
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_idx_q   <= '0;
      tx_shift_q <= '0;
      tx_len64_q <= 1'b0;
      txd_q      <= 1'b1;
    end else begin
      cr_q       <= cr_d;
      mr_q       <= mr_d;
      tdr_q      <= tdr_d;
      rdr_q      <= rdr_d;
      tdre_q     <= tdre_d;
      rdrf_q     <= rdrf_d;
      fe_q       <= fe_d;
      ovrn_q     <= ovrn_d;
      sync_q     <= sync_d;
      rx_prev_q  <= rx_prev_d;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_idx_q   <= rx_idx_d;
      rx_shift_q <= rx_shift_d;
      rx_len64_q <= rx_len64_d;
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_idx_q   <= tx_idx_d;
      tx_shift_q <= tx_shift_d;
      tx_len64_q <= tx_len64_d;
      txd_q      <= txd_d;
    end
  end

endmodule

// File: tb/tb_ikbd_host_acia.sv
// tb_ikbd_host_acia
// Directed bench for ikbd_host_acia. It runs one task per scenario, and each
// task compares the DUT outputs against values worked out by hand. CLK_EN
// pulses once every 4 CLK cycles. Host accesses are placed one clock after a
// tick, so a write never lands on the same edge as a TX load.
module tb_ikbd_host_acia;

  logic       CLK = 1'b0;
  logic       RST;
  logic       CLK_EN;
  logic       CS, STB, RS, RW;
  logic [7:0] DI;
  logic [7:0] DO;
  logic       IRQ;
  logic       RXD;
  logic       TXD;
  logic       RTS_n;

  int errors = 0;
  int checks = 0;

  ikbd_host_acia #(.SYNC_STAGES(2)) dut (
    .CLK(CLK), .RST(RST), .CLK_EN(CLK_EN), .CS(CS), .STB(STB), .RS(RS),
    .RW(RW), .DI(DI), .DO(DO), .IRQ(IRQ), .RXD(RXD), .TXD(TXD), .RTS_n(RTS_n)
  );

  always #5 CLK = ~CLK;

  // Baud tick: one CLK-wide pulse every 4 clocks, changed on falling edges.
  initial begin
    CLK_EN = 1'b0;
    forever begin
      repeat (3) @(negedge CLK);
      CLK_EN = 1'b1;
      @(negedge CLK);
      CLK_EN = 1'b0;
    end
  end

  // Return at the rising edge of the n-th tick from now.
  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      while (CLK_EN !== 1'b1) @(posedge CLK);
    end
  endtask

  // Move to the falling edge just after a tick.
  task automatic align_after_tick;
    @(posedge CLK);
    while (CLK_EN !== 1'b1) @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic bus_write(input logic rs, input logic [7:0] d);
    align_after_tick();
    CS = 1'b1; STB = 1'b1; RW = 1'b1; RS = rs; DI = d;
    @(negedge CLK);
    CS = 1'b0; STB = 1'b0; RW = 1'b0; RS = 1'b0; DI = 8'h00;
  endtask

  task automatic bus_read(input logic rs, output logic [7:0] d);
    align_after_tick();
    CS = 1'b1; STB = 1'b1; RW = 1'b0; RS = rs;
    #1 d = DO;
    @(negedge CLK);
    CS = 1'b0; STB = 1'b0; RS = 1'b0;
  endtask

  // Wait (bounded) for TXD low, then sample each bit near mid-bit.
  task automatic capture_tx(input int nbits, input int len, output logic [19:0] bits,
                            output logic [7:0] st0, output logic timed_out);
    timed_out = 1'b1;
    bits = '1;
    st0 = 8'h00;
    for (int i = 0; i < 4000; i++) begin
      @(negedge CLK);
      if (TXD === 1'b0) begin
        timed_out = 1'b0;
        break;
      end
    end
    if (!timed_out) begin
      st0 = DO;
      wait_ticks(len / 2);
      #1 bits[0] = TXD;
      for (int k = 1; k < nbits; k++) begin
        wait_ticks(len);
        #1 bits[k] = TXD;
      end
    end
  endtask

  // Drive one 8N1 frame on RXD, LSB first, with the chosen stop level.
  task automatic send_rx(input logic [7:0] b, input logic stopb, input int len);
    logic [9:0] fr;
    fr = {stopb, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      RXD = fr[i];
      wait_ticks(len);
    end
    @(negedge CLK);
    RXD = 1'b1;
  endtask

  task automatic test_reset;
    logic [7:0] d;
    RST = 1'b1; CS = 1'b0; STB = 1'b0; RS = 1'b0; RW = 1'b0; DI = 8'h00; RXD = 1'b1;
    repeat (4) @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    bus_read(1'b0, d);
    checks++; if (d !== 8'h00) begin errors++; $display("[TB] FAIL reset_status: got %h want 00", d); end
    checks++; if (TXD !== 1'b1) begin errors++; $display("[TB] FAIL reset_txd: got %b want 1", TXD); end
    checks++; if (RTS_n !== 1'b0) begin errors++; $display("[TB] FAIL reset_rts: got %b want 0", RTS_n); end
    checks++; if (IRQ !== 1'b0) begin errors++; $display("[TB] FAIL reset_irq: got %b want 0", IRQ); end
    bus_read(1'b1, d);
    checks++; if (d !== 8'h00) begin errors++; $display("[TB] FAIL reset_rdr: got %h want 00", d); end
  endtask

  task automatic test_tx;
    logic [7:0] d, st0;
    logic [19:0] bits;
    logic to;
    bus_write(1'b0, 8'h15);
    bus_read(1'b0, d);
    checks++; if (d !== 8'h02) begin errors++; $display("[TB] FAIL tx_cr15_status: got %h want 02", d); end
    checks++; if (TXD !== 1'b1) begin errors++; $display("[TB] FAIL tx_idle_txd: got %b want 1", TXD); end
    checks++; if (IRQ !== 1'b0) begin errors++; $display("[TB] FAIL tx_idle_irq: got %b want 0", IRQ); end
    bus_write(1'b1, 8'hA5);
    capture_tx(10, 16, bits, st0, to);
    checks++; if (to !== 1'b0) begin errors++; $display("[TB] FAIL tx_a5_start: got timeout want start bit"); end
    checks++; if (bits[9:0] !== 10'b1101001010) begin errors++; $display("[TB] FAIL tx_a5_frame: got %b want 1101001010", bits[9:0]); end
    checks++; if (st0 !== 8'h02) begin errors++; $display("[TB] FAIL tx_tdre_after_load: got %h want 02", st0); end
    wait_ticks(10);
    #1;
    checks++; if (TXD !== 1'b1) begin errors++; $display("[TB] FAIL tx_after_frame_txd: got %b want 1", TXD); end
  endtask

  task automatic test_tx_irq;
    logic [7:0] d, st0;
    logic [19:0] bits;
    logic to;
    bus_write(1'b0, 8'h35);
    bus_read(1'b0, d);
    checks++; if (d !== 8'h82) begin errors++; $display("[TB] FAIL txirq_status: got %h want 82", d); end
    bus_write(1'b1, 8'h69);
    checks++; if (IRQ !== 1'b0) begin errors++; $display("[TB] FAIL txirq_pending: got %b want 0", IRQ); end
    capture_tx(10, 16, bits, st0, to);
    checks++; if (to !== 1'b0) begin errors++; $display("[TB] FAIL txirq_start: got timeout want start bit"); end
    checks++; if (st0 !== 8'h82) begin errors++; $display("[TB] FAIL txirq_after_load: got %h want 82", st0); end
    checks++; if (bits[9:0] !== {1'b1, 8'h69, 1'b0}) begin errors++; $display("[TB] FAIL txirq_frame: got %b want %b", bits[9:0], {1'b1, 8'h69, 1'b0}); end
    wait_ticks(10);
  endtask

  task automatic test_back_to_back;
    logic [7:0] st0;
    logic [19:0] bits;
    logic to;
    bus_write(1'b0, 8'h15);
    bus_write(1'b1, 8'h5A);
    wait_ticks(2);
    bus_write(1'b1, 8'hC3);
    capture_tx(20, 16, bits, st0, to);
    checks++; if (to !== 1'b0) begin errors++; $display("[TB] FAIL b2b_start: got timeout want start bit"); end
    checks++; if (bits !== {1'b1, 8'hC3, 1'b0, 1'b1, 8'h5A, 1'b0}) begin errors++; $display("[TB] FAIL b2b_frames: got %b want %b", bits, {1'b1, 8'hC3, 1'b0, 1'b1, 8'h5A, 1'b0}); end
    wait_ticks(20);
  endtask

  task automatic test_rx;
    logic [7:0] d;
    bus_write(1'b0, 8'h95);
    send_rx(8'h3C, 1'b1, 16);
    bus_read(1'b0, d);
    checks++; if (d !== 8'h83) begin errors++; $display("[TB] FAIL rx_status: got %h want 83", d); end
    checks++; if (IRQ !== 1'b1) begin errors++; $display("[TB] FAIL rx_irq: got %b want 1", IRQ); end
    bus_read(1'b1, d);
    checks++; if (d !== 8'h3C) begin errors++; $display("[TB] FAIL rx_rdr: got %h want 3c", d); end
    bus_read(1'b0, d);
    checks++; if (d !== 8'h02) begin errors++; $display("[TB] FAIL rx_after_read: got %h want 02", d); end
    checks++; if (IRQ !== 1'b0) begin errors++; $display("[TB] FAIL rx_irq_cleared: got %b want 0", IRQ); end
  endtask

  task automatic test_overrun;
    logic [7:0] d;
    send_rx(8'h11, 1'b1, 16);
    send_rx(8'h22, 1'b1, 16);
    bus_read(1'b0, d);
    checks++; if (d !== 8'hA3) begin errors++; $display("[TB] FAIL ovrn_status: got %h want a3", d); end
    bus_read(1'b1, d);
    checks++; if (d !== 8'h11) begin errors++; $display("[TB] FAIL ovrn_rdr_kept: got %h want 11", d); end
    bus_read(1'b0, d);
    checks++; if (d !== 8'h02) begin errors++; $display("[TB] FAIL ovrn_cleared: got %h want 02", d); end
  endtask

  task automatic test_framing_and_glitch;
    logic [7:0] d;
    send_rx(8'h5A, 1'b0, 16);
    bus_read(1'b0, d);
    checks++; if (d !== 8'h93) begin errors++; $display("[TB] FAIL fe_status: got %h want 93", d); end
    bus_read(1'b1, d);
    checks++; if (d !== 8'h5A) begin errors++; $display("[TB] FAIL fe_rdr: got %h want 5a", d); end
    @(negedge CLK);
    RXD = 1'b0;
    wait_ticks(4);
    @(negedge CLK);
    RXD = 1'b1;
    wait_ticks(40);
    bus_read(1'b0, d);
    checks++; if (d[0] !== 1'b0) begin errors++; $display("[TB] FAIL glitch_rdrf: got %b want 0", d[0]); end
    checks++; if (IRQ !== 1'b0) begin errors++; $display("[TB] FAIL glitch_irq: got %b want 0", IRQ); end
  endtask

  task automatic test_master_reset_and_break;
    logic [7:0] d, st0;
    logic [19:0] bits;
    logic to;
    int highs;
    bus_write(1'b1, 8'hF0);
    wait_ticks(40);
    bus_write(1'b0, 8'h03);
    checks++; if (TXD !== 1'b1) begin errors++; $display("[TB] FAIL mr_txd: got %b want 1", TXD); end
    bus_read(1'b0, d);
    checks++; if (d !== 8'h00) begin errors++; $display("[TB] FAIL mr_status: got %h want 00", d); end
    wait_ticks(20);
    #1;
    checks++; if (TXD !== 1'b1) begin errors++; $display("[TB] FAIL mr_txd_held: got %b want 1", TXD); end
    bus_write(1'b0, 8'h15);
    bus_read(1'b0, d);
    checks++; if (d !== 8'h02) begin errors++; $display("[TB] FAIL mr_release_status: got %h want 02", d); end
    bus_write(1'b0, 8'h55);
    checks++; if (RTS_n !== 1'b1) begin errors++; $display("[TB] FAIL rts_high: got %b want 1", RTS_n); end
    bus_write(1'b0, 8'h75);
    checks++; if (RTS_n !== 1'b0) begin errors++; $display("[TB] FAIL rts_break: got %b want 0", RTS_n); end
    bus_write(1'b1, 8'h81);
    highs = 0;
    for (int i = 0; i < 20; i++) begin
      wait_ticks(10);
      #1 if (TXD !== 1'b0) highs++;
    end
    checks++; if (highs != 0) begin errors++; $display("[TB] FAIL break_held: got %0d high samples want 0", highs); end
    bus_read(1'b0, d);
    checks++; if (d !== 8'h00) begin errors++; $display("[TB] FAIL break_tdr_held: got %h want 00", d); end
    bus_write(1'b0, 8'h15);
    @(negedge CLK);
    checks++; if (TXD !== 1'b1) begin errors++; $display("[TB] FAIL break_release_txd: got %b want 1", TXD); end
    capture_tx(10, 16, bits, st0, to);
    checks++; if (to !== 1'b0) begin errors++; $display("[TB] FAIL break_resume_start: got timeout want start bit"); end
    checks++; if (bits[9:0] !== {1'b1, 8'h81, 1'b0}) begin errors++; $display("[TB] FAIL break_resume_frame: got %b want %b", bits[9:0], {1'b1, 8'h81, 1'b0}); end
    wait_ticks(10);
  endtask

  task automatic test_baud64;
    logic [7:0] d, st0;
    logic [19:0] bits;
    logic to;
    bus_write(1'b0, 8'h16);
    bus_write(1'b1, 8'hC6);
    capture_tx(10, 64, bits, st0, to);
    checks++; if (to !== 1'b0) begin errors++; $display("[TB] FAIL b64_start: got timeout want start bit"); end
    checks++; if (bits[9:0] !== {1'b1, 8'hC6, 1'b0}) begin errors++; $display("[TB] FAIL b64_tx_frame: got %b want %b", bits[9:0], {1'b1, 8'hC6, 1'b0}); end
    wait_ticks(40);
    bus_write(1'b0, 8'h96);
    send_rx(8'h9D, 1'b1, 64);
    bus_read(1'b0, d);
    checks++; if (d !== 8'h83) begin errors++; $display("[TB] FAIL b64_rx_status: got %h want 83", d); end
    bus_read(1'b1, d);
    checks++; if (d !== 8'h9D) begin errors++; $display("[TB] FAIL b64_rx_rdr: got %h want 9d", d); end
  endtask

  task automatic test_reset_mid_rx;
    logic [7:0] d;
    logic [9:0] fr;
    bus_write(1'b0, 8'h95);
    fr = {1'b1, 8'hE7, 1'b0};
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      RXD = fr[i];
      wait_ticks(16);
    end
    @(negedge CLK);
    RST = 1'b1;
    RXD = 1'b1;
    repeat (3) @(negedge CLK);
    checks++; if (DO !== 8'h00) begin errors++; $display("[TB] FAIL rst_mid_status: got %h want 00", DO); end
    checks++; if (TXD !== 1'b1) begin errors++; $display("[TB] FAIL rst_mid_txd: got %b want 1", TXD); end
    RST = 1'b0;
    bus_write(1'b0, 8'h95);
    wait_ticks(200);
    bus_read(1'b0, d);
    checks++; if (d !== 8'h02) begin errors++; $display("[TB] FAIL rst_no_late_byte: got %h want 02", d); end
    bus_read(1'b1, d);
    checks++; if (d !== 8'h00) begin errors++; $display("[TB] FAIL rst_rdr: got %h want 00", d); end
  endtask

  initial begin
    $display("[TB] start");
    test_reset();
    test_tx();
    test_tx_irq();
    test_back_to_back();
    test_rx();
    test_overrun();
    test_framing_and_glitch();
    test_master_reset_and_break();
    test_baud64();
    test_reset_mid_rx();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
